// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the board-level reset sequencer.
//
// Contents:
//   state_e   - sequencer states, in the order the resets are released
//   cntWidth  - width of the shared sequencing counter, sized from the
//               larger of the lock-stable and pixel-delay intervals
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOCK = 2'd1,
    ST_CORE = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // The counter never needs to reach the interval itself, only
  // interval-1. It is never narrower than one bit.
  function automatic int cntWidth(input int lockStable, input int pixDelay);
    int maxVal;
    maxVal = (lockStable > pixDelay) ? lockStable : pixDelay;
    return (maxVal <= 1) ? 1 : $clog2(maxVal);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser for bringing an asynchronous level
// into the clk_i domain. The output has two edges of latency and
// clears to 0 while rstN_i is low.
//
// Ports:
//   clk_i   - destination clock
//   rstN_i  - asynchronous active-low clear
//   d_i     - asynchronous input level
//   q_o     - synchronised level
module sync_2ff (
  input  logic clk_i,
  input  logic rstN_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  // Both stages are kept adjacent by the ASYNC_REG attribute so the
  // first stage gets a full cycle to resolve metastability.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer. Waits for the clock generator lock to be
// stable, releases the core reset, then after a fixed delay releases
// the pixel-pipeline reset. Loss of lock after core release, or a
// debounced pushbutton press at any time, returns to the held state and
// the whole sequence restarts.
//
// Ports:
//   i_clk       - system clock
//   i_rst_n     - asynchronous active-low reset
//   i_locked    - clock-generator lock, asynchronous to i_clk
//   i_btn       - pushbutton reset request, asynchronous, active-high
//   o_rst_core  - core reset, active-high, registered
//   o_rst_pix   - pixel-domain reset, active-high, registered
//   o_ready     - high once both resets are released
module reset_sequencer #(
  parameter int LOCK_STABLE = 1024,
  parameter int PIX_DELAY   = 16,
  parameter int DEBOUNCE    = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_locked,
  input  logic i_btn,
  output logic o_rst_core,
  output logic o_rst_pix,
  output logic o_ready
);

  import reset_sequencer_pkg::*;

  localparam int CNT_W = cntWidth(LOCK_STABLE, PIX_DELAY);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(PIX_DELAY - 1);
  localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE);

  logic lockS;
  logic btnS;
  logic btnDb;

  logic [DB_W-1:0]  dbCnt_q, dbCnt_d;
  logic [CNT_W-1:0] seqCnt_q, seqCnt_d;
  state_e           state_q, state_d;
  logic             rstCore_q, rstCore_d;
  logic             rstPix_q, rstPix_d;
  logic             ready_q, ready_d;

  sync_2ff u_syncLock (
    .clk_i  (i_clk),
    .rstN_i (i_rst_n),
    .d_i    (i_locked),
    .q_o    (lockS)
  );

  sync_2ff u_syncBtn (
    .clk_i  (i_clk),
    .rstN_i (i_rst_n),
    .d_i    (i_btn),
    .q_o    (btnS)
  );

  // Debounce: the counter saturates, so a press is seen as a level that
  // stays high for as long as the button is held.
  always_comb begin
    dbCnt_d = dbCnt_q;
    if (!btnS) begin
      dbCnt_d = '0;
    end else if (dbCnt_q != DB_MAX) begin
      dbCnt_d = dbCnt_q + 1'b1;
    end
  end

  assign btnDb = (dbCnt_q == DB_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dbCnt_q <= '0;
    end else begin
      dbCnt_q <= dbCnt_d;
    end
  end

  // State and shared counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_HOLD;
      seqCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      seqCnt_q <= seqCnt_d;
    end
  end

  // Next state. A debounced press wins over everything; lock loss only
  // aborts once the core is out of reset, since in ST_LOCK it merely
  // restarts the stability count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HOLD: begin
        if (!btnDb) state_d = ST_LOCK;
      end
      ST_LOCK: begin
        if (btnDb) begin
          state_d = ST_HOLD;
        end else if (lockS && (seqCnt_q == LOCK_LAST)) begin
          state_d = ST_CORE;
        end
      end
      ST_CORE: begin
        if (btnDb || !lockS) begin
          state_d = ST_HOLD;
        end else if (seqCnt_q == PIX_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (btnDb || !lockS) state_d = ST_HOLD;
      end
      default: state_d = ST_HOLD;
    endcase

    // The counter restarts from zero in every new state; any lock glitch
    // while waiting for stability also restarts it.
    seqCnt_d = seqCnt_q;
    if (state_d != state_q) begin
      seqCnt_d = '0;
    end else begin
      unique case (state_q)
        ST_LOCK: seqCnt_d = lockS ? (seqCnt_q + 1'b1) : '0;
        ST_CORE: seqCnt_d = seqCnt_q + 1'b1;
        default: seqCnt_d = seqCnt_q;
      endcase
    end
  end

  // Outputs decoded from the next state so the registered resets move on
  // the same edge as the state. Pixel reset is only released in ST_RUN,
  // which is only reachable after core release, so ordering is preserved.
  always_comb begin
    rstCore_d = (state_d == ST_HOLD) || (state_d == ST_LOCK);
    rstPix_d  = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rstCore_q <= 1'b1;
      rstPix_q  <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      rstCore_q <= rstCore_d;
      rstPix_q  <= rstPix_d;
      ready_q   <= ready_d;
    end
  end

  assign o_rst_core = rstCore_q;
  assign o_rst_pix  = rstPix_q;
  assign o_ready    = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer with small parameters. A reference model
// tracks synchronised lock/button history and counts consecutive good
// lock edges since leaving hold; expected outputs follow from that count.
module tb_reset_sequencer;

  localparam int LS = 8;
  localparam int PD = 4;
  localparam int DB = 16;

  logic clk;
  logic rstN;
  logic locked;
  logic btn;
  logic rstCore;
  logic rstPix;
  logic ready;

  int assertCount = 0;
  int failCount   = 0;
  int edgeNum     = 0;

  // Reference model state
  logic lockPipe[$];
  logic btnPipe[$];
  int   btnRun;
  bit   inHold;
  int   goodEdges;
  logic expCore;
  logic expPix;
  logic expReady;

  reset_sequencer #(
    .LOCK_STABLE (LS),
    .PIX_DELAY   (PD),
    .DEBOUNCE    (DB)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_locked   (locked),
    .i_btn      (btn),
    .o_rst_core (rstCore),
    .o_rst_pix  (rstPix),
    .o_ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs as a function of the model's progress count
  task automatic modelOutputs();
    expCore  = inHold || (goodEdges < LS);
    expPix   = inHold || (goodEdges < LS + PD);
    expReady = !expPix;
  endtask

  task automatic modelReset();
    lockPipe  = {1'b0, 1'b0};
    btnPipe   = {1'b0, 1'b0};
    btnRun    = 0;
    inHold    = 1'b1;
    goodEdges = 0;
    edgeNum   = 0;
    modelOutputs();
  endtask

  // One clock edge of the model; lk/bt are the input levels sampled there
  task automatic modelEdge(input logic lk, input logic bt);
    logic lockS;
    logic btnS;
    bit   btnDb;
    lockS = lockPipe[0];
    btnS  = btnPipe[0];
    btnDb = (btnRun >= DB);
    if (btnDb) begin
      inHold    = 1'b1;
      goodEdges = 0;
    end else if (inHold) begin
      inHold    = 1'b0;
      goodEdges = 0;
    end else if (!lockS) begin
      if (goodEdges >= LS) inHold = 1'b1;
      goodEdges = 0;
    end else if (goodEdges < LS + PD) begin
      goodEdges++;
    end
    btnRun = btnS ? ((btnRun < DB) ? btnRun + 1 : DB) : 0;
    void'(lockPipe.pop_front());
    lockPipe.push_back(lk);
    void'(btnPipe.pop_front());
    btnPipe.push_back(bt);
    modelOutputs();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, edgeNum, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("rst_core", {31'b0, rstCore}, {31'b0, expCore});
    checkOutput("rst_pix",  {31'b0, rstPix},  {31'b0, expPix});
    checkOutput("ready",    {31'b0, ready},   {31'b0, expReady});
    checkOutput("order",    {31'b0, (rstPix | ~rstCore)}, 32'd1);
    checkOutput("readyNotPix", {31'b0, (ready ^ rstPix)}, 32'd1);
  endtask

  // Drive inputs, take one edge, advance the model, then check outputs
  task automatic applyStimulus(input logic lk, input logic bt);
    locked = lk;
    btn    = bt;
    @(posedge clk);
    edgeNum++;
    modelEdge(lk, bt);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    rstN = 1'b0;
    #2;
    checkOutput("resetCore",  {31'b0, rstCore}, 32'd1);
    checkOutput("resetPix",   {31'b0, rstPix},  32'd1);
    checkOutput("resetReady", {31'b0, ready},   32'd0);
    @(posedge clk);
    #3;
    rstN = 1'b1;
    modelReset();
  endtask

  initial begin
    int coreFall;
    int pixFall;
    int coreRise;
    int rel;
    bit readyDropped;

    rstN   = 1'b1;
    locked = 1'b1;
    btn    = 1'b0;
    #1;

    // Power-up with lock already high
    $display("[TB] power-up sequence");
    doReset();
    coreFall = -1;
    pixFall  = -1;
    for (int e = 0; e < 20; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (coreFall < 0 && rstCore === 1'b0) coreFall = edgeNum;
      if (pixFall < 0 && rstPix === 1'b0) pixFall = edgeNum;
    end
    checkOutput("powerUpCoreEdge", coreFall, LS + 2);
    checkOutput("powerUpPixEdge",  pixFall,  LS + 2 + PD);

    // One-cycle lock glitch sampled at edge 6 restarts the count
    $display("[TB] lock glitch during stability wait");
    doReset();
    coreFall = -1;
    pixFall  = -1;
    for (int e = 1; e <= 30; e++) begin
      applyStimulus((e == 6) ? 1'b0 : 1'b1, 1'b0);
      if (coreFall < 0 && rstCore === 1'b0) coreFall = edgeNum;
      if (pixFall < 0 && rstPix === 1'b0) pixFall = edgeNum;
    end
    checkOutput("glitchCoreEdge", coreFall, 8 + LS);
    checkOutput("glitchPixEdge",  pixFall,  8 + LS + PD);

    // Lock loss while running, then recovery
    $display("[TB] lock loss in run");
    coreRise = -1;
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(1'b0, 1'b0);
      if (coreRise < 0 && rstCore === 1'b1 && ready === 1'b0) coreRise = e;
    end
    checkOutput("lockLossEdge", coreRise, 3);
    coreFall = -1;
    pixFall  = -1;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (coreFall < 0 && rstCore === 1'b0) coreFall = e;
      if (pixFall < 0 && rstPix === 1'b0) pixFall = e;
    end
    checkOutput("relockCoreEdge", coreFall, LS + 2);
    checkOutput("relockPixEdge",  pixFall,  LS + 2 + PD);

    // Short button bounces are ignored
    $display("[TB] button bounce and press");
    readyDropped = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int e = 0; e < 10; e++) begin
        applyStimulus(1'b1, 1'b1);
        if (ready !== 1'b1) readyDropped = 1'b1;
      end
      for (int e = 0; e < 10; e++) begin
        applyStimulus(1'b1, 1'b0);
        if (ready !== 1'b1) readyDropped = 1'b1;
      end
    end
    checkOutput("bounceIgnored", {31'b0, readyDropped}, 32'd0);

    // A held press forces the resets on, release lets it resequence
    coreRise = -1;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b1, 1'b1);
      if (coreRise < 0 && rstCore === 1'b1) coreRise = e;
    end
    checkOutput("pressEdge", coreRise, 2 + DB + 1);
    for (int e = 0; e < 40; e++) applyStimulus(1'b1, 1'b0);
    checkOutput("resequenced", {31'b0, ready}, 32'd1);

    // Asynchronous reset in the middle of the core-released phase
    $display("[TB] async reset mid-sequence");
    doReset();
    for (int e = 0; e < LS + 3; e++) applyStimulus(1'b1, 1'b0);
    checkOutput("inCorePhase", {31'b0, rstCore}, 32'd0);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("asyncCore",  {31'b0, rstCore}, 32'd1);
    checkOutput("asyncPix",   {31'b0, rstPix},  32'd1);
    checkOutput("asyncReady", {31'b0, ready},   32'd0);
    #2;
    rstN = 1'b1;
    modelReset();
    coreFall = -1;
    pixFall  = -1;
    for (int e = 0; e < 20; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (coreFall < 0 && rstCore === 1'b0) coreFall = edgeNum;
      if (pixFall < 0 && rstPix === 1'b0) pixFall = edgeNum;
    end
    checkOutput("reinitCoreEdge", coreFall, LS + 2);
    checkOutput("reinitPixEdge",  pixFall,  LS + 2 + PD);

    // Randomised lock and button activity against the model
    $display("[TB] random stimulus");
    doReset();
    for (int s = 0; s < 200; s++) begin
      int   len;
      logic lk;
      logic bt;
      len = $urandom_range(1, 40);
      lk  = ($urandom_range(0, 7) != 0);
      bt  = ($urandom_range(0, 5) == 0);
      for (int e = 0; e < len; e++) applyStimulus(lk, bt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
